shift_sequencer: RTL

//  Sequencer for the WIDTH-bit JK shift register (shifts toward bit 0; serial in at MSB).

---
 rtl/shift_sequencer.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/shift_sequencer.sv
// -----------------------------------------------------------------------------
// shift_sequencer
//   Drives a WIDTH-bit JK shift register (shifts toward bit 0, serial in at the
//   MSB). A parallel word is taken over a valid/ready handshake. The sequencer
//   then strobes the register's preset for one cycle and issues exactly SHIFTS
//   shift-enable cycles, forwarding fill_bit as the serial input. Finally it
//   pulses done and rests for max(GAP,1) cycles before accepting another word.
//   A shadow copy of the register is kept so that its LSB is available as
//   serial_out.
//
// Ports
//   clockpulse     in   1      system clock, rising edge
//   clear          in   1      asynchronous active-low reset
//   word_valid     in   1      parallel word offered
//   word_in        in   WIDTH  parallel word
//   word_ready     out  1      sequencer idle and able to take a word
//   fill_bit       in   1      bit shifted into the MSB on every shift
//   abort          in   1      synchronous abort of the word in LOAD/SHIFT
//   enable_preset  out  1      one-cycle load strobe to the register
//   preset         out  WIDTH  word to load (zero outside the load strobe)
//   shift_enable   out  1      register shifts on this cycle's edge
//   serial_input   out  1      fill_bit while shift_enable=1, else 0
//   serial_out     out  1      LSB of the shadow register
//   busy           out  1      high in LOAD/SHIFT/DONE
//   done           out  1      one-cycle pulse after the last shift
// -----------------------------------------------------------------------------
module shift_sequencer #(
    parameter int WIDTH  = 4,
    parameter int SHIFTS = 4,
    parameter int GAP    = 0
) (
    input  logic             clockpulse,
    input  logic             clear,
    input  logic             word_valid,
    input  logic [WIDTH-1:0] word_in,
    output logic             word_ready,
    input  logic             fill_bit,
    input  logic             abort,
    output logic             enable_preset,
    output logic [WIDTH-1:0] preset,
    output logic             shift_enable,
    output logic             serial_input,
    output logic             serial_out,
    output logic             busy,
    output logic             done
);

    localparam int CW      = $clog2(SHIFTS + 1);
    localparam int GAP_EFF = (GAP < 1) ? 1 : GAP;

    // Count value held during the final shift cycle of a word.
    localparam logic [CW-1:0] LAST_CNT = CW'(SHIFTS - 1);
    // Gap value held during the final DONE cycle.
    localparam logic [3:0]    GAP_LAST = 4'(GAP_EFF - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t           state_r;
    state_t           state_nx_s;
    logic [CW-1:0]    count_r;
    logic [CW-1:0]    count_nx_s;
    logic [3:0]       gap_r;
    logic [3:0]       gap_nx_s;
    logic [WIDTH-1:0] shadow_r;
    logic [WIDTH-1:0] shadow_nx_s;

    logic             enable_preset_r;
    logic [WIDTH-1:0] preset_r;
    logic             shift_enable_r;
    logic             busy_r;
    logic             done_r;

    // Next-state, counter and shadow update for the sequencer FSM.
    always_comb begin
        state_nx_s  = state_r;
        count_nx_s  = count_r;
        gap_nx_s    = gap_r;
        shadow_nx_s = shadow_r;
        case (state_r)
            ST_IDLE: begin
                // abort in the same cycle as word_valid refuses the word
                if (word_valid && !abort) begin
                    state_nx_s  = ST_LOAD;
                    shadow_nx_s = word_in;
                end else begin
                    state_nx_s  = ST_IDLE;
                end
            end
            ST_LOAD: begin
                count_nx_s = {CW{1'b0}};
                if (abort) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (abort) begin
                    // shadow deliberately left untouched on an aborted edge
                    state_nx_s = ST_IDLE;
                    count_nx_s = {CW{1'b0}};
                end else begin
                    shadow_nx_s = {fill_bit, shadow_r[WIDTH-1:1]};
                    count_nx_s  = count_r + CW'(1);
                    if (count_r == LAST_CNT) begin
                        state_nx_s = ST_DONE;
                        gap_nx_s   = 4'd0;
                    end else begin
                        state_nx_s = ST_SHIFT;
                    end
                end
            end
            ST_DONE: begin
                if (gap_r >= GAP_LAST) begin
                    state_nx_s = ST_IDLE;
                    gap_nx_s   = 4'd0;
                end else begin
                    state_nx_s = ST_DONE;
                    gap_nx_s   = gap_r + 4'd1;
                end
            end
            default: begin
                state_nx_s  = ST_IDLE;
                count_nx_s  = {CW{1'b0}};
                gap_nx_s    = 4'd0;
                shadow_nx_s = shadow_r;
            end
        endcase
    end

    // State, counters, shadow and Moore output registers.
    // Outputs are computed from the next state so they line up with state_r.
    always_ff @(posedge clockpulse or negedge clear) begin
        if (!clear) begin
            state_r         <= ST_IDLE;
            count_r         <= {CW{1'b0}};
            gap_r           <= 4'd0;
            shadow_r        <= {WIDTH{1'b0}};
            enable_preset_r <= 1'b0;
            preset_r        <= {WIDTH{1'b0}};
            shift_enable_r  <= 1'b0;
            busy_r          <= 1'b0;
            done_r          <= 1'b0;
        end else begin
            state_r         <= state_nx_s;
            count_r         <= count_nx_s;
            gap_r           <= gap_nx_s;
            shadow_r        <= shadow_nx_s;
            enable_preset_r <= (state_nx_s == ST_LOAD);
            // LOAD is only entered from a handshake, so shadow_nx_s is the new word
            preset_r        <= (state_nx_s == ST_LOAD) ? shadow_nx_s : {WIDTH{1'b0}};
            shift_enable_r  <= (state_nx_s == ST_SHIFT);
            busy_r          <= (state_nx_s != ST_IDLE);
            done_r          <= (state_r == ST_SHIFT) && (state_nx_s == ST_DONE);
        end
    end

    assign word_ready    = (state_r == ST_IDLE);
    assign enable_preset = enable_preset_r;
    assign preset        = preset_r;
    assign shift_enable  = shift_enable_r;
    // The register shifts in the fill bit present at the shifting edge.
    assign serial_input  = shift_enable_r & fill_bit;
    assign serial_out    = shadow_r[0];
    assign busy          = busy_r;
    assign done          = done_r;

endmodule
